// File: rtl/sprite_anim_layer.sv
// Sprite compositing layer: N square sprites with shadowed positions, vsync-paced
// animation frames, external ROM fetch with lookahead, colour keying and priority.
module sprite_anim_layer #(
    parameter int          NUM_SPRITES = 2,
    parameter int          SZ_LOG2     = 6,
    parameter int          NUM_FRAMES  = 2,
    parameter int          FRAME_DIV   = 8,
    parameter int          ROM_LAT     = 1,
    parameter logic [23:0] KEY_COLOR   = 24'hFFFFCC,
    localparam int         FB          = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1,
    localparam int         AW          = FB + 2 * SZ_LOG2
) (
    input  logic                        pixel_clk,
    input  logic                        rst_n,
    input  logic [9:0]                  x_pos,
    input  logic [8:0]                  y_pos,
    input  logic                        frame_start,
    input  logic                        run,
    input  logic [NUM_SPRITES-1:0]      anim_en,
    input  logic [10*NUM_SPRITES-1:0]   spr_x,
    input  logic [9*NUM_SPRITES-1:0]    spr_y,
    output logic [AW*NUM_SPRITES-1:0]   rom_addr,
    input  logic [24*NUM_SPRITES-1:0]   rom_data,
    output logic [23:0]                 rgb,
    output logic                        hit,
    output logic [2:0]                  hit_id
);

    localparam int LEAD = ROM_LAT + 2;
    localparam int DW   = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam int SZ   = 1 << SZ_LOG2;

    logic [NUM_SPRITES-1:0][9:0]    r_sx;
    logic [NUM_SPRITES-1:0][8:0]    r_sy;
    logic [NUM_SPRITES-1:0]         r_aen;
    logic [NUM_SPRITES-1:0][FB-1:0] r_frame;
    logic [DW-1:0]                  r_div;
    logic [AW*NUM_SPRITES-1:0]      r_rom_addr;
    logic [ROM_LAT:0][NUM_SPRITES-1:0] r_inbox;
    logic [23:0]                    r_rgb;
    logic                           r_hit;
    logic [2:0]                     r_hit_id;

    logic [10:0]                    w_px;
    logic [10:0]                    w_py;
    logic                           w_div_wrap;
    logic [NUM_SPRITES-1:0]         w_inbox;
    logic [AW*NUM_SPRITES-1:0]      w_addr;
    logic                           w_any;
    logic [2:0]                     w_id;
    logic [23:0]                    w_rgb;

    // Lookahead is 11 bits wide so it never wraps back onto the left edge.
    assign w_px       = {1'b0, x_pos} + 11'(LEAD);
    assign w_py       = {2'b0, y_pos};
    assign w_div_wrap = (r_div == DW'(FRAME_DIV - 1));

    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_spr
        logic [10:0] w_sx;
        logic [10:0] w_sy;
        logic [10:0] w_dx;
        logic [10:0] w_dy;
        assign w_sx = {1'b0, r_sx[g]};
        assign w_sy = {2'b0, r_sy[g]};
        assign w_dx = w_px - w_sx;
        assign w_dy = w_py - w_sy;
        assign w_inbox[g] = (w_px >= w_sx) && (w_px < w_sx + 11'(SZ)) &&
                            (w_py >= w_sy) && (w_py < w_sy + 11'(SZ));
        assign w_addr[g*AW +: AW] = {r_frame[g], w_dy[SZ_LOG2-1:0], w_dx[SZ_LOG2-1:0]};
    end

    // Shadow capture and animation stepping; stepping uses the previously captured enables.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sx    <= {NUM_SPRITES{10'h3FF}};
            r_sy    <= {NUM_SPRITES{9'h1FF}};
            r_aen   <= '0;
            r_frame <= '0;
            r_div   <= '0;
        end else if (frame_start) begin
            r_div <= w_div_wrap ? '0 : r_div + DW'(1);
            for (int i = 0; i < NUM_SPRITES; i++) begin
                if (w_div_wrap && r_aen[i]) begin
                    r_frame[i] <= (r_frame[i] == FB'(NUM_FRAMES - 1)) ? '0 : r_frame[i] + FB'(1);
                end
                r_sx[i] <= spr_x[10*i +: 10];
                r_sy[i] <= spr_y[9*i +: 9];
            end
            r_aen <= anim_en;
        end
    end

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rom_addr <= '0;
            r_inbox    <= '0;
        end else begin
            r_rom_addr <= w_addr;
            r_inbox[0] <= w_inbox;
            for (int k = 1; k <= ROM_LAT; k++) begin
                r_inbox[k] <= r_inbox[k-1];
            end
        end
    end

    // Descending scan so the lowest-index opaque sprite overrides the rest.
    always_comb begin
        w_any = 1'b0;
        w_id  = 3'd0;
        w_rgb = 24'd0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (r_inbox[ROM_LAT][i] && (rom_data[24*i +: 24] != KEY_COLOR)) begin
                w_any = 1'b1;
                w_id  = 3'(i);
                w_rgb = rom_data[24*i +: 24];
            end
        end
    end

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rgb    <= '0;
            r_hit    <= 1'b0;
            r_hit_id <= '0;
        end else if (w_any && !run) begin
            r_rgb    <= w_rgb;
            r_hit    <= 1'b1;
            r_hit_id <= w_id;
        end else begin
            r_rgb    <= '0;
            r_hit    <= 1'b0;
            r_hit_id <= '0;
        end
    end

    assign rom_addr = r_rom_addr;
    assign rgb      = r_rgb;
    assign hit      = r_hit;
    assign hit_id   = r_hit_id;

endmodule

// File: tb/tb_sprite_anim_layer.sv
// Bench for sprite_anim_layer: directed raster scans, echo ROM, scoreboard of
// expected {hit, hit_id, rgb} words checked LEAD cycles after each driven pixel.
module tb_sprite_anim_layer;

    localparam int LEAD = 3;
    localparam logic [23:0] KEY = 24'hFFFFCC;

    logic        clk;
    logic        rst_n;
    logic [9:0]  x_pos;
    logic [8:0]  y_pos;
    logic        frame_start;
    logic        run;
    logic [1:0]  anim_en;
    logic [19:0] spr_x;
    logic [17:0] spr_y;
    logic [25:0] rom_addr;
    logic [47:0] rom_data;
    logic [23:0] rgb;
    logic        hit;
    logic [2:0]  hit_id;

    sprite_anim_layer #(
        .NUM_SPRITES(2), .SZ_LOG2(6), .NUM_FRAMES(2), .FRAME_DIV(3),
        .ROM_LAT(1), .KEY_COLOR(KEY)
    ) dut (
        .pixel_clk(clk), .rst_n(rst_n), .x_pos(x_pos), .y_pos(y_pos),
        .frame_start(frame_start), .run(run), .anim_en(anim_en),
        .spr_x(spr_x), .spr_y(spr_y), .rom_addr(rom_addr), .rom_data(rom_data),
        .rgb(rgb), .hit(hit), .hit_id(hit_id)
    );

    // clock / cycle counter
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // external ROM: word echoes the address; sprite 0 left half keyed out in key_mode
    bit key_mode = 0;

    function automatic logic [23:0] rom_word(int i, logic [12:0] a);
        if (i == 0 && key_mode && a[5:0] < 6'd32) return KEY;
        return {8'hA0 + 8'(i), 3'b000, a};
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) rom_data[24*i +: 24] <= rom_word(i, rom_addr[13*i +: 13]);
    end

    // reference model state
    int   m_sx[2];
    int   m_sy[2];
    int   m_frame[2];
    int   m_div;
    logic [1:0] m_aen;
    bit   m_run = 0;

    function automatic logic [27:0] exp_px(int x, int y);
        logic [27:0] r;
        logic [12:0] a;
        logic [23:0] d;
        int px;
        r  = '0;
        px = x + LEAD;
        for (int i = 1; i >= 0; i--) begin
            if (px >= m_sx[i] && px < m_sx[i] + 64 && y >= m_sy[i] && y < m_sy[i] + 64) begin
                a = {1'(m_frame[i]), 6'(y - m_sy[i]), 6'(px - m_sx[i])};
                d = rom_word(i, a);
                if (d != KEY) r = {1'b1, 3'(i), d};
            end
        end
        if (m_run) r = '0;
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_sx[i] = 1023;
            m_sy[i] = 511;
            m_frame[i] = 0;
        end
        m_div = 0;
        m_aen = 2'b00;
    endtask

    // scoreboard
    logic [27:0] exp_q[$];
    int          due_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    always @(negedge clk) begin
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            logic [27:0] e;
            logic [27:0] g;
            e = exp_q.pop_front();
            void'(due_q.pop_front());
            g = {hit, hit_id, rgb};
            n_tests++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL pix cyc=%0d: got hit=%0b id=%0d rgb=%06h, exp hit=%0b id=%0d rgb=%06h",
                         cyc, g[27], g[26:24], g[23:0], e[27], e[26:24], e[23:0]);
            end
        end
    end

    task automatic chk(string nm, logic [31:0] got, logic [31:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, exp %0h", nm, got, expv);
        end
    endtask

    // driver tasks
    task automatic drive(int x, int y);
        x_pos = 10'(x);
        y_pos = 9'(y);
        exp_q.push_back(exp_px(x, y));
        due_q.push_back(cyc + LEAD);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) drive(0, 480);
    endtask

    task automatic scan(int y, int x0, int x1);
        for (int x = x0; x <= x1; x++) drive(x, y);
        idle(4);
    endtask

    task automatic set_spr(int i, int x, int y);
        spr_x[10*i +: 10] = 10'(x);
        spr_y[9*i +: 9]   = 9'(y);
    endtask

    task automatic pulse_fs();
        bit step;
        frame_start = 1'b1;
        drive(0, 480);
        frame_start = 1'b0;
        step  = (m_div == 2);
        m_div = step ? 0 : m_div + 1;
        for (int i = 0; i < 2; i++) begin
            if (step && m_aen[i]) m_frame[i] = 1 - m_frame[i];
            m_sx[i] = int'(spr_x[10*i +: 10]);
            m_sy[i] = int'(spr_y[9*i +: 9]);
        end
        m_aen = anim_en;
        idle(2);
    endtask

    initial begin
        rst_n = 1'b0;
        x_pos = '0;
        y_pos = 9'd480;
        frame_start = 1'b0;
        run = 1'b0;
        anim_en = 2'b00;
        spr_x = '0;
        spr_y = '0;
        model_reset();
        #2;
        chk("reset_rgb", 32'(rgb), 32'd0);
        chk("reset_hit", 32'(hit), 32'd0);
        chk("reset_hit_id", 32'(hit_id), 32'd0);
        chk("reset_rom_addr", 32'(rom_addr), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(4);

        // nothing visible before the first frame_start
        set_spr(0, 256, 100);
        set_spr(1, 1000, 400);
        scan(100, 250, 330);

        // basic hit
        pulse_fs();
        scan(100, 250, 330);

        // moved mid-frame: no effect until next frame_start
        set_spr(0, 400, 100);
        scan(100, 250, 330);
        pulse_fs();
        scan(100, 390, 470);

        // colour key and priority
        set_spr(0, 320, 50);
        set_spr(1, 320, 50);
        key_mode = 1;
        pulse_fs();
        scan(50, 315, 390);
        scan(60, 340, 360);
        key_mode = 0;
        idle(2);

        // animation: sprite 0 animated, sprite 1 held
        anim_en = 2'b01;
        set_spr(0, 256, 100);
        set_spr(1, 256, 200);
        for (int p = 0; p < 9; p++) begin
            pulse_fs();
            scan(100, 254, 258);
            scan(200, 254, 258);
        end

        // right-edge clipping, no wrap onto next line
        anim_en = 2'b00;
        set_spr(0, 1000, 400);
        set_spr(1, 600, 200);
        pulse_fs();
        scan(200, 590, 639);
        scan(201, 0, 30);

        // run hides the layer
        set_spr(0, 256, 100);
        pulse_fs();
        run = 1'b1;
        m_run = 1;
        idle(4);
        scan(100, 250, 330);
        run = 1'b0;
        m_run = 0;
        idle(4);

        // reset in the middle of a hit
        for (int x = 250; x <= 275; x++) drive(x, 100);
        rst_n = 1'b0;
        #1;
        chk("midrst_hit", 32'(hit), 32'd0);
        chk("midrst_rgb", 32'(rgb), 32'd0);
        chk("midrst_rom_addr", 32'(rom_addr), 32'd0);
        exp_q.delete();
        due_q.delete();
        model_reset();
        idle(3);
        rst_n = 1'b1;
        scan(100, 250, 330);
        pulse_fs();
        scan(100, 250, 330);

        for (int k = 0; k < 20 && due_q.size() > 0; k++) @(posedge clk);
        #1;
        if (due_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d pending, exp 0", due_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
